// File: rtl/mux_pkg.sv
// Shared types and helpers for the N-channel registered mux.
// Imported by the arbiter and the mux top.
package mux_pkg;

    typedef enum logic {
        MUX_SEL_EXT = 1'b0,
        MUX_SEL_RR  = 1'b1
    } mux_mode_e;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr.
// ptr moves past the winner only when the grant is actually taken.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    localparam int SEL_W = clog2_min1(NUM_INPUTS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_INPUTS-1:0] req,
    input  logic                  advance,
    output logic                  grant_valid,
    output logic [SEL_W-1:0]      grant_idx
);

    logic [SEL_W-1:0] ptr_q, ptr_d;

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        int k;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int o = NUM_INPUTS - 1; o >= 0; o--) begin
            k = int'(ptr_q) + o;
            if (k >= NUM_INPUTS) k = k - NUM_INPUTS;
            if (req[k]) begin
                grant_valid = 1'b1;
                grant_idx   = SEL_W'(k);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && grant_valid) begin
            if (grant_idx == SEL_W'(NUM_INPUTS - 1)) ptr_d = '0;
            else ptr_d = grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/muxn_arb.sv
// N-channel registered mux with valid/ready on every channel.
// Channel choice comes from select or from a round-robin arbiter.
module muxn_arb
    import mux_pkg::*;
#(
    parameter int        DATA_SIZE  = 32,
    parameter int        NUM_INPUTS = 4,
    parameter mux_mode_e ARB_MODE   = MUX_SEL_EXT,
    localparam int       SEL_W      = clog2_min1(NUM_INPUTS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_INPUTS*DATA_SIZE-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]           in_valid,
    output logic [NUM_INPUTS-1:0]           in_ready,
    input  logic [SEL_W-1:0]                select,
    output logic [DATA_SIZE-1:0]            out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [SEL_W-1:0]                out_src
);

    logic                 load, xfer, gnt_v;
    logic [SEL_W-1:0]     gnt_idx;
    logic [DATA_SIZE-1:0] gnt_data;
    logic [DATA_SIZE-1:0] data_q, data_d;
    logic [SEL_W-1:0]     src_q, src_d;
    logic                 valid_q, valid_d;

    assign load = !valid_q || out_ready;
    assign xfer = gnt_v && load && !reset;

    generate
        if (ARB_MODE == MUX_SEL_RR) begin : g_rr
            logic unused_sel;
            assign unused_sel = ^select;
            rr_arbiter #(
                .NUM_INPUTS(NUM_INPUTS)
            ) u_rr (
                .clk        (clk),
                .reset      (reset),
                .req        (in_valid),
                .advance    (xfer),
                .grant_valid(gnt_v),
                .grant_idx  (gnt_idx)
            );
        end else begin : g_ext
            // Out-of-range select matches no channel, so no grant.
            always_comb begin
                gnt_v   = 1'b0;
                gnt_idx = select;
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    if (select == SEL_W'(i) && in_valid[i]) gnt_v = 1'b1;
                end
            end
        end
    endgenerate

    always_comb begin
        gnt_data = '0;
        in_ready = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                gnt_data    = in_data[i*DATA_SIZE +: DATA_SIZE];
                in_ready[i] = xfer;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        src_d   = src_q;
        if (xfer) begin
            valid_d = 1'b1;
            data_d  = gnt_data;
            src_d   = gnt_idx;
        end else if (load) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_src   = src_q;

endmodule

// File: tb/tb_muxn_arb.sv
// Bench for muxn_arb: select mode (N=4, N=3) and round-robin mode (N=4).
// Directed scenarios plus a randomized run against a reference model.
module tb_muxn_arb;
    import mux_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [127:0] idat [3];
    logic [3:0]  iv   [3];
    logic [1:0]  sel  [3];
    logic        ordy [3];
    logic [3:0]  ir0, ir1;
    logic [2:0]  ir2;
    logic [31:0] od [3];
    logic        ov [3];
    logic [1:0]  os [3];

    int checks = 0;
    int errors = 0;

    // Reference model state, one slot per DUT
    bit          m_valid [3];
    logic [31:0] m_data  [3];
    int          m_src   [3];
    int          m_ptr   [3];

    muxn_arb #(.DATA_SIZE(32), .NUM_INPUTS(4), .ARB_MODE(MUX_SEL_EXT)) u_ext4 (
        .clk(clk), .reset(rst), .in_data(idat[0]), .in_valid(iv[0]),
        .in_ready(ir0), .select(sel[0]), .out_data(od[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_src(os[0]));

    muxn_arb #(.DATA_SIZE(32), .NUM_INPUTS(4), .ARB_MODE(MUX_SEL_RR)) u_rr4 (
        .clk(clk), .reset(rst), .in_data(idat[1]), .in_valid(iv[1]),
        .in_ready(ir1), .select(sel[1]), .out_data(od[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_src(os[1]));

    muxn_arb #(.DATA_SIZE(32), .NUM_INPUTS(3), .ARB_MODE(MUX_SEL_EXT)) u_ext3 (
        .clk(clk), .reset(rst), .in_data(idat[2][95:0]), .in_valid(iv[2][2:0]),
        .in_ready(ir2), .select(sel[2]), .out_data(od[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_src(os[2]));

    function automatic int nch(int d);
        return (d == 2) ? 3 : 4;
    endfunction

    function automatic int exp_grant(int d);
        int n, k;
        n = nch(d);
        if (d == 1) begin
            for (int o = 0; o < n; o++) begin
                k = (m_ptr[d] + o) % n;
                if (iv[d][k]) return k;
            end
            return -1;
        end
        if (int'(sel[d]) < n && iv[d][sel[d]]) return int'(sel[d]);
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready(int d);
        int g;
        g = exp_grant(d);
        if (rst || (m_valid[d] && !ordy[d]) || g < 0) return 4'b0;
        return 4'b1 << g;
    endfunction

    function automatic logic [3:0] ir_of(int d);
        if (d == 0) return ir0;
        if (d == 1) return ir1;
        return {1'b0, ir2};
    endfunction

    task automatic tick();
        int g [3];
        bit ld [3];
        for (int d = 0; d < 3; d++) begin
            ld[d] = !m_valid[d] || ordy[d];
            g[d]  = exp_grant(d);
        end
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                m_valid[d] = 0; m_data[d] = '0; m_src[d] = 0; m_ptr[d] = 0;
            end else if (ld[d] && g[d] >= 0) begin
                m_valid[d] = 1;
                m_data[d]  = idat[d][g[d]*32 +: 32];
                m_src[d]   = g[d];
                m_ptr[d]   = (g[d] + 1) % nch(d);
            end else if (ld[d]) begin
                m_valid[d] = 0;
            end
        end
        #1;
    endtask

    task automatic idle();
        for (int d = 0; d < 3; d++) begin
            iv[d] = '0; sel[d] = '0; ordy[d] = 1'b1;
        end
    endtask

    task automatic test_reset();
        idle();
        for (int d = 0; d < 3; d++) begin
            iv[d] = 4'hF;
            idat[d] = {$urandom, $urandom, $urandom, $urandom};
        end
        rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ir_of(d) !== 4'b0) begin
                errors++;
                $display("FAIL reset_in_ready[%0d]: got %b expected 0000", d, ir_of(d));
            end
        end
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ov[d] !== 1'b0 || od[d] !== 32'h0 || os[d] !== 2'd0) begin
                errors++;
                $display("FAIL reset_out[%0d]: got v=%b d=%h s=%0d expected 0/0/0",
                         d, ov[d], od[d], os[d]);
            end
        end
        rst = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_ext_select();
        idle();
        sel[0] = 2'd2;
        iv[0]  = 4'b0100;
        idat[0][64 +: 32] = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (ir0 !== 4'b0100) begin
            errors++;
            $display("FAIL ext_in_ready: got %b expected 0100", ir0);
        end
        tick();
        iv[0] = '0;
        checks++;
        if (od[0] !== 32'hDEAD_BEEF || os[0] !== 2'd2 || ov[0] !== 1'b1) begin
            errors++;
            $display("FAIL ext_out: got d=%h s=%0d v=%b expected deadbeef/2/1",
                     od[0], os[0], ov[0]);
        end
        tick();
        checks++;
        if (ov[0] !== 1'b0 || od[0] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL ext_drain: got v=%b d=%h expected 0/deadbeef", ov[0], od[0]);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        idle();
        sel[0] = 2'd1; iv[0] = 4'b0010; idat[0][32 +: 32] = a;
        tick();
        ordy[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            iv[0]   = 4'hF;
            sel[0]  = 2'($urandom_range(0, 3));
            idat[0] = {$urandom, $urandom, $urandom, $urandom};
            #1;
            checks++;
            if (ir0 !== 4'b0 || od[0] !== a || os[0] !== 2'd1 || ov[0] !== 1'b1) begin
                errors++;
                $display("FAIL stall[%0d]: got r=%b d=%h s=%0d v=%b expected 0000/%h/1/1",
                         c, ir0, od[0], os[0], ov[0], a);
            end
            tick();
        end
        ordy[0] = 1'b1; sel[0] = 2'd3; idat[0][96 +: 32] = b;
        #1;
        checks++;
        if (ir0 !== 4'b1000) begin
            errors++;
            $display("FAIL unstall_ready: got %b expected 1000", ir0);
        end
        tick();
        checks++;
        if (od[0] !== b || os[0] !== 2'd3 || ov[0] !== 1'b1) begin
            errors++;
            $display("FAIL unstall_out: got d=%h s=%0d v=%b expected %h/3/1",
                     od[0], os[0], ov[0], b);
        end
        idle();
        tick();
    endtask

    task automatic test_rr_all();
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        idle();
        iv[1]   = 4'hF;
        idat[1] = {$urandom, $urandom, $urandom, $urandom};
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (int'(os[1]) != exp_seq[c] || ov[1] !== 1'b1 ||
                od[1] !== idat[1][exp_seq[c]*32 +: 32]) begin
                errors++;
                $display("FAIL rr_all[%0d]: got s=%0d v=%b d=%h expected s=%0d v=1",
                         c, os[1], ov[1], od[1], exp_seq[c]);
            end
        end
    endtask

    task automatic test_rr_skip();
        int exp_seq [2] = '{3, 1};
        // One more all-valid grant (ch1) leaves the pointer at 2.
        tick();
        iv[1] = '0;
        tick();
        iv[1] = 4'b1010;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (int'(os[1]) != exp_seq[c] || ov[1] !== 1'b1) begin
                errors++;
                $display("FAIL rr_skip[%0d]: got s=%0d v=%b expected %0d/1",
                         c, os[1], ov[1], exp_seq[c]);
            end
        end
        ordy[1] = 1'b0;
        tick();
        tick();
        checks++;
        if (os[1] !== 2'd1 || ov[1] !== 1'b1 || ir1 !== 4'b0) begin
            errors++;
            $display("FAIL rr_stall: got s=%0d v=%b r=%b expected 1/1/0000",
                     os[1], ov[1], ir1);
        end
        ordy[1] = 1'b1;
        #1;
        checks++;
        if (ir1 !== 4'b1000) begin
            errors++;
            $display("FAIL rr_resume_ready: got %b expected 1000", ir1);
        end
        tick();
        checks++;
        if (os[1] !== 2'd3 || ov[1] !== 1'b1) begin
            errors++;
            $display("FAIL rr_resume: got s=%0d v=%b expected 3/1", os[1], ov[1]);
        end
        idle();
        tick();
    endtask

    task automatic test_out_of_range();
        logic [31:0] w;
        w = $urandom;
        idle();
        sel[2] = 2'd2; iv[2] = 4'b0100; idat[2][64 +: 32] = w;
        tick();
        checks++;
        if (ov[2] !== 1'b1 || os[2] !== 2'd2 || od[2] !== w) begin
            errors++;
            $display("FAIL n3_top: got v=%b s=%0d d=%h expected 1/2/%h",
                     ov[2], os[2], od[2], w);
        end
        sel[2] = 2'd3; iv[2] = 4'hF;
        #1;
        checks++;
        if (ir2 !== 3'b0) begin
            errors++;
            $display("FAIL n3_oor_ready: got %b expected 000", ir2);
        end
        tick();
        checks++;
        if (ov[2] !== 1'b0 || os[2] !== 2'd2 || od[2] !== w) begin
            errors++;
            $display("FAIL n3_oor_out: got v=%b s=%0d d=%h expected 0/2/%h",
                     ov[2], os[2], od[2], w);
        end
        idle();
    endtask

    task automatic test_reset_mid_stall();
        idle();
        sel[0] = 2'd1; iv[0] = 4'hF; iv[1] = 4'hF;
        idat[0] = {$urandom, $urandom, $urandom, 32'h1};
        idat[1] = {$urandom, $urandom, $urandom, 32'h1};
        tick();
        ordy[0] = 1'b0; ordy[1] = 1'b0;
        tick();
        checks++;
        if (ov[0] !== 1'b1 || ov[1] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_stall: got v0=%b v1=%b expected 1/1", ov[0], ov[1]);
        end
        rst = 1'b1; ordy[0] = 1'b1; ordy[1] = 1'b1;
        #1;
        checks++;
        if (ir0 !== 4'b0 || ir1 !== 4'b0 || ir2 !== 3'b0) begin
            errors++;
            $display("FAIL mid_reset_ready: got %b %b %b expected zeros", ir0, ir1, ir2);
        end
        tick();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (ov[d] !== 1'b0 || od[d] !== 32'h0 || os[d] !== 2'd0) begin
                errors++;
                $display("FAIL mid_reset_out[%0d]: got v=%b d=%h s=%0d expected 0/0/0",
                         d, ov[d], od[d], os[d]);
            end
        end
        #1;
        checks++;
        if (ir1 !== 4'b0001) begin
            errors++;
            $display("FAIL ptr_after_reset: got %b expected 0001", ir1);
        end
        idle();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int d = 0; d < 3; d++) begin
                iv[d]   = 4'($urandom);
                sel[d]  = 2'($urandom_range(0, 3));
                ordy[d] = ($urandom_range(0, 3) != 0);
                idat[d] = {$urandom, $urandom, $urandom, $urandom};
            end
            #1;
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (ir_of(d) !== exp_ready(d)) begin
                    errors++;
                    $display("FAIL rand_ready[%0d] cyc %0d: got %b expected %b",
                             d, c, ir_of(d), exp_ready(d));
                end
            end
            tick();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (ov[d] !== m_valid[d] || od[d] !== m_data[d] || int'(os[d]) != m_src[d]) begin
                    errors++;
                    $display("FAIL rand_out[%0d] cyc %0d: got v=%b d=%h s=%0d expected v=%b d=%h s=%0d",
                             d, c, ov[d], od[d], os[d], m_valid[d], m_data[d], m_src[d]);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            m_valid[d] = 0; m_data[d] = '0; m_src[d] = 0; m_ptr[d] = 0;
            idat[d] = '0;
        end
        rst = 1'b1;
        idle();
        #2;
        test_reset();
        test_ext_select();
        test_backpressure();
        test_rr_all();
        test_rr_skip();
        test_out_of_range();
        test_reset_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
